block_ram_arbiter: RTL

Two-port TileLink-UL arbiter that shares a single `block_ram` A/D channel pair between two requesters, typically instruction fetch (port 0) and load/store (port 1). Each cycle it grants at most one A-channel request to the RAM, remembers which port was granted, and routes the RAM's single-cycle D-channel response back to that port. Fairness is either round-robin or fixed priority with a starvation guard.

---
 rtl/block_ram_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/block_ram_arbiter.sv
// Two-port TileLink-UL arbiter sharing one block_ram A/D channel pair.
// Define BLOCK_RAM_ARB_RR_EN for round-robin; otherwise fixed priority with a port 1 starvation guard.
package block_ram_arbiter_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
  } tilelink_d;

endpackage

module block_ram_arbiter
  import block_ram_arbiter_pkg::*;
#(
  parameter int unsigned starve_limit = 8
) (
  input  logic      clock,
  input  logic      reset_n,
  input  tilelink_a req0_tla,
  input  tilelink_a req1_tla,
  output logic      req0_gnt,
  output logic      req1_gnt,
  output tilelink_d req0_tld,
  output tilelink_d req1_tld,
  output tilelink_a ram_tla,
  input  tilelink_d ram_tld
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  logic  valid0;
  logic  valid1;
  logic  gnt0;
  logic  gnt1;
  logic  grant;
  logic  issued_q;
  port_e win;
  port_e last_q;
  port_e owner_q;

  assign valid0 = req0_tla.a_valid;
  assign valid1 = req1_tla.a_valid;

`ifdef BLOCK_RAM_ARB_RR_EN
  always_comb begin
    win = PORT0;
    if (valid0 && valid1) begin
      win = (last_q == PORT0) ? PORT1 : PORT0;
    end else if (valid1) begin
      win = PORT1;
    end
  end
`else
  localparam logic [7:0] STARVE_LIMIT = 8'(starve_limit);

  logic [7:0] starve_q;

  always_comb begin
    win = PORT0;
    if (valid1 && (!valid0 || (starve_q >= STARVE_LIMIT))) begin
      win = PORT1;
    end
  end

  // Counts consecutive denied cycles of port 1, saturating at 255.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else if (!valid1 || gnt1) begin
      starve_q <= '0;
    end else if (starve_q != '1) begin
      starve_q <= starve_q + 8'd1;
    end
  end
`endif

  assign gnt0     = reset_n && valid0 && (win == PORT0);
  assign gnt1     = reset_n && valid1 && (win == PORT1);
  assign grant    = gnt0 | gnt1;
  assign req0_gnt = gnt0;
  assign req1_gnt = gnt1;

  always_comb begin
    ram_tla         = gnt1 ? req1_tla : req0_tla;
    ram_tla.a_valid = grant;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      issued_q <= 1'b0;
      last_q   <= PORT1;
    end else begin
      issued_q <= grant;
      if (grant) begin
        last_q <= win;
      end
    end
  end

  // owner and last-granted port capture the same value on every grant; owner is only
  // consulted while issued_q is set (i.e. after a grant), so one register serves both.
  assign owner_q = last_q;

  // Response routing is also blanked while reset is held, dropping an in-flight reply.
  always_comb begin
    req0_tld         = ram_tld;
    req1_tld         = ram_tld;
    req0_tld.d_valid = ram_tld.d_valid && reset_n && issued_q && (owner_q == PORT0);
    req1_tld.d_valid = ram_tld.d_valid && reset_n && issued_q && (owner_q == PORT1);
  end

endmodule
